// File: rtl/me_mem_loader.sv
// Loader and result collector for the motion-estimation engine. It streams the
// R and S memories in, launches the engine, and hands the result downstream.
module me_mem_loader #(
  parameter int RMEM_MAX = 256,
  parameter int SMEM_MAX = 1024,
  parameter int TIMEOUT  = 8191
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       start,
  input  logic [7:0] AddressR,
  input  logic [9:0] AddressS1,
  input  logic [9:0] AddressS2,
  output logic [7:0] R,
  output logic [7:0] S1,
  output logic [7:0] S2,
  input  logic       completed,
  input  logic [7:0] BestDist,
  input  logic [3:0] motionX,
  input  logic [3:0] motionY,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_best_dist,
  output logic [3:0] res_motion_x,
  output logic [3:0] res_motion_y,
  output logic       res_timeout,
  output logic       busy
);

  typedef enum logic [2:0] {LOAD_R, LOAD_S, START, RUN, RESULT} state_t;

  localparam logic [9:0]  R_LAST  = 10'(RMEM_MAX - 1);
  localparam logic [9:0]  S_LAST  = 10'(SMEM_MAX - 1);
  localparam logic [12:0] TO_LAST = 13'(TIMEOUT - 1);

  state_t      state, stateNext;
  logic [9:0]  wPtr, wPtrNext;
  logic [12:0] runCnt, runCntNext;
  logic [7:0]  bestNext;
  logic [3:0]  mxNext, myNext;
  logic        toNext;
  logic        wrR, wrS;

  logic [7:0] rMem [0:RMEM_MAX-1];
  logic [7:0] sMem [0:SMEM_MAX-1];

  // Memories carry no reset so contents survive a mid-job reset.
  always_ff @(posedge clk) begin
    if (wrR) rMem[wPtr[7:0]] <= in_data;
    if (wrS) sMem[wPtr]      <= in_data;
  end

  assign R  = rMem[AddressR];
  assign S1 = sMem[AddressS1];
  assign S2 = sMem[AddressS2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= LOAD_R;
      wPtr          <= '0;
      runCnt        <= '0;
      res_best_dist <= '0;
      res_motion_x  <= '0;
      res_motion_y  <= '0;
      res_timeout   <= 1'b0;
    end else begin
      state         <= stateNext;
      wPtr          <= wPtrNext;
      runCnt        <= runCntNext;
      res_best_dist <= bestNext;
      res_motion_x  <= mxNext;
      res_motion_y  <= myNext;
      res_timeout   <= toNext;
    end
  end

  always_comb begin
    stateNext  = state;
    wPtrNext   = wPtr;
    runCntNext = runCnt;
    bestNext   = res_best_dist;
    mxNext     = res_motion_x;
    myNext     = res_motion_y;
    toNext     = res_timeout;
    in_ready   = 1'b0;
    start      = 1'b0;
    res_valid  = 1'b0;
    wrR        = 1'b0;
    wrS        = 1'b0;
    busy       = !(state == LOAD_R && wPtr == 10'd0);
    case (state)
      LOAD_R: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wrR = 1'b1;
          if (wPtr == R_LAST) begin
            stateNext = LOAD_S;
            wPtrNext  = '0;
          end else begin
            wPtrNext = wPtr + 10'd1;
          end
        end
      end
      LOAD_S: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wrS = 1'b1;
          if (wPtr == S_LAST) begin
            stateNext = START;
            wPtrNext  = '0;
          end else begin
            wPtrNext = wPtr + 10'd1;
          end
        end
      end
      START: begin
        start      = 1'b1;
        runCntNext = '0;
        stateNext  = RUN;
      end
      RUN: begin
        runCntNext = runCnt + 13'd1;
        // A result arriving on the last allowed cycle still counts as real.
        if (completed) begin
          bestNext  = BestDist;
          mxNext    = motionX;
          myNext    = motionY;
          toNext    = 1'b0;
          stateNext = RESULT;
        end else if (runCnt == TO_LAST) begin
          bestNext  = 8'hFF;
          mxNext    = '0;
          myNext    = '0;
          toNext    = 1'b1;
          stateNext = RESULT;
        end
      end
      RESULT: begin
        res_valid = 1'b1;
        if (res_ready) stateNext = LOAD_R;
      end
      default: stateNext = LOAD_R;
    endcase
  end

endmodule
